// File: rtl/xres_cond.sv
// xres_cond: per-channel synchronise, deglitch and stretch of active-low reset requests plus a combined core reset.
// Defining XRES_COND_STATUS_EN adds per-channel assert/glitch event counters.
module xres_cond #(
  parameter int N_CH        = 1,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 4,
  parameter int HOLD_CYC    = 16
) (
`ifdef USE_POWER_PINS
  inout  wire                VPWR,
  inout  wire                VGND,
`endif
  input  logic               clock,
  input  logic               reset,
  input  logic [N_CH-1:0]    a_n,
  input  logic [N_CH-1:0]    ch_en,
`ifdef XRES_COND_STATUS_EN
  input  logic               evt_clr,
  output logic [8*N_CH-1:0]  evt_cnt,
  output logic [8*N_CH-1:0]  glitch_cnt,
`endif
  output logic [N_CH-1:0]    x_n,
  output logic               core_rst_n
);
  localparam int CNT_W = $clog2(FILT_CYC > HOLD_CYC ? FILT_CYC : HOLD_CYC) + 1;
  localparam logic [CNT_W-1:0] FILT_M1 = CNT_W'(FILT_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD_CYC - 1);
  // Bit 1 of the state is the asserted flag, so x_n comes straight off one flop.
  typedef enum logic [1:0] {IDLE = 2'b00, QUAL_A = 2'b01, ACTIVE = 2'b10, QUAL_R = 2'b11} state_t;
  logic core_q;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic s;
    assign s = sync_q[SYNC_STAGES-1];
    always_ff @(posedge clock) begin
      if (reset) begin
        sync_q  <= '1;
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        sync_q  <= {sync_q[SYNC_STAGES-2:0], a_n[i]};
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        IDLE: begin
          if (!s) begin
            state_d = QUAL_A;
            cnt_d   = '0;
          end
        end
        QUAL_A: begin
          if (s) state_d = IDLE;
          else if (cnt_q == FILT_M1) begin
            state_d = ACTIVE;
            cnt_d   = '0;
          end else cnt_d = cnt_q + 1'b1;
        end
        ACTIVE: begin
          if (s && cnt_q == HOLD_M1) begin
            state_d = QUAL_R;
            cnt_d   = '0;
          end else cnt_d = (cnt_q == HOLD_M1) ? cnt_q : cnt_q + 1'b1;
        end
        QUAL_R: begin
          if (!s) begin
            state_d = ACTIVE;
            cnt_d   = HOLD_M1;
          end else if (cnt_q == FILT_M1) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else cnt_d = cnt_q + 1'b1;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
      if (!ch_en[i]) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
    assign x_n[i] = ~state_q[1];
`ifdef XRES_COND_STATUS_EN
    logic [7:0] evt_q, glt_q;
    logic evt_inc, glt_inc;
    assign evt_inc = state_q == QUAL_A && state_d == ACTIVE;
    assign glt_inc = state_q == QUAL_A && state_d == IDLE && ch_en[i];
    always_ff @(posedge clock) begin
      if (reset || evt_clr) begin
        evt_q <= '0;
        glt_q <= '0;
      end else begin
        if (evt_inc && evt_q != 8'hff) evt_q <= evt_q + 8'd1;
        if (glt_inc && glt_q != 8'hff) glt_q <= glt_q + 8'd1;
      end
    end
    assign evt_cnt[8*i +: 8]    = evt_q;
    assign glitch_cnt[8*i +: 8] = glt_q;
`endif
  end
  always_ff @(posedge clock) core_q <= reset ? 1'b1 : &x_n;
  assign core_rst_n = core_q;
endmodule
